// File: rtl/gear_pkg.sv
// Shared constants and FSM state encoding for the GeAr(8,2,4) error detection/correction unit.
// The CORRECT state exists only when GEAR_ECU_CORRECT_EN is defined.
package gear_pkg;

    localparam int GEAR_N       = 8;
    localparam int GEAR_R       = 2;
    localparam int GEAR_P       = 4;
    localparam int GEAR_ERR_BIT = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
`ifdef GEAR_ECU_CORRECT_EN
        CORRECT = 2'd2,
`endif
        DONE    = 2'd3
    } state_t;

    // Carry out of a 4-bit block with no carry-in, from per-bit generate/propagate.
    function automatic logic carry4(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/gear_n8_r2_p4_err_det.sv
// Combinational GeAr(8,2,4) approximate adder plus detection of the dropped carry reaching bit 6.
module gear_n8_r2_p4_err_det
    import gear_pkg::*;
(
    input  logic [GEAR_N-1:0] in1,
    input  logic [GEAR_N-1:0] in2,
    output logic [GEAR_N:0]   approx_sum,
    output logic              err
);

    logic [5:0] g_s;
    logic [5:0] p_s;
    logic [5:0] s1_s;
    logic       c6_s;
    logic       c2_s;
    logic [2:0] s2_hi_s;

    // Lower sub-adder gives bits [5:0]; upper sub-adder starts at bit 2 with no carry-in,
    // so its bits [6:4] only see the carry generated inside bits [5:2].
    always_comb begin
        g_s        = in1[5:0] & in2[5:0];
        p_s        = in1[5:0] ^ in2[5:0];
        s1_s       = in1[5:0] + in2[5:0];
        c6_s       = carry4(g_s[5:2], p_s[5:2]);
        s2_hi_s    = {1'b0, in1[7:6]} + {1'b0, in2[7:6]} + {2'b00, c6_s};
        c2_s       = g_s[1] | (p_s[1] & g_s[0]);
        approx_sum = {s2_hi_s, s1_s};
        err        = c2_s & (&p_s[5:2]);
    end

endmodule

// File: rtl/gear_n8_r2_p4_ecu.sv
// GeAr(8,2,4) error detection/correction unit: handshake FSM, result registers, saturating error counter.
// Define GEAR_ECU_CORRECT_EN to add the CORRECT state and emit the exact sum.
module gear_n8_r2_p4_ecu
    import gear_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in1,
    input  logic [7:0]       in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       res,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    state_t             state_r;
    state_t             next_state_s;
    logic [7:0]         a_r;
    logic [7:0]         b_r;
    logic [8:0]         res_r;
    logic               err_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [8:0]         approx_s;
    logic               err_s;
    logic               in_ready_s;
    logic               out_valid_s;

    gear_n8_r2_p4_err_det u_err_det (
        .in1        (a_r),
        .in2        (b_r),
        .approx_sum (approx_s),
        .err        (err_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = EVAL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EVAL: begin
`ifdef GEAR_ECU_CORRECT_EN
                if (err_s) begin
                    next_state_s = CORRECT;
                end else begin
                    next_state_s = DONE;
                end
`else
                next_state_s = DONE;
`endif
            end
`ifdef GEAR_ECU_CORRECT_EN
            CORRECT: next_state_s = DONE;
`endif
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Operand capture, result/flag registers and the +64 fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= 8'd0;
            b_r   <= 8'd0;
            res_r <= 9'd0;
            err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= in1;
                        b_r <= in2;
                    end
                end
                EVAL: begin
                    res_r <= approx_s;
                    err_r <= err_s;
                end
`ifdef GEAR_ECU_CORRECT_EN
                CORRECT: res_r[8:6] <= res_r[8:6] + 3'd1;
`endif
                default: ;
            endcase
        end
    end

    // Saturating error counter; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == EVAL) && err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign res       = res_r;
    assign err_flag  = err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_gear_n8_r2_p4_ecu.sv
// Self-checking bench: default-width unit and a CNT_W=2 unit run in lockstep on the same stimulus.
module tb_gear_n8_r2_p4_ecu;

`ifdef GEAR_ECU_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in1 = 8'd0;
    logic [7:0]  in2 = 8'd0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;

    logic        in_ready_a, out_valid_a, err_flag_a;
    logic [8:0]  res_a;
    logic [15:0] err_cnt_a;
    logic        in_ready_b, out_valid_b, err_flag_b;
    logic [8:0]  res_b;
    logic [1:0]  err_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_a    = 0;
    int cnt_b    = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] r;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    gear_n8_r2_p4_ecu u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in1(in1), .in2(in2), .out_valid(out_valid_a), .out_ready(out_ready),
        .res(res_a), .err_flag(err_flag_a), .err_cnt(err_cnt_a), .cnt_clr(cnt_clr)
    );

    gear_n8_r2_p4_ecu #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in1(in1), .in2(in2), .out_valid(out_valid_b), .out_ready(out_ready),
        .res(res_b), .err_flag(err_flag_b), .err_cnt(err_cnt_b), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction; returns with the result presented (and consumed if out_ready=1).
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [8:0] er, input logic ee, input int el);
        int w;
        int lat;
        w = 0;
        while (!in_ready_a && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_idle", {31'd0, in_ready_a}, 32'd1);
        in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        check("in_ready_busy", {31'd0, in_ready_a}, 32'd0);
        while (!out_valid_a && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, el);
        check("res", {23'd0, res_a}, {23'd0, er});
        check("err_flag", {31'd0, err_flag_a}, {31'd0, ee});
        check("res_b", {23'd0, res_b}, {23'd0, er});
        check("out_valid_b", {31'd0, out_valid_b}, 32'd1);
        if (ee) begin
            cnt_a++;
            if (cnt_b < 3) cnt_b++;
        end
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vecs[0] = '{8'h03, 8'h01, 9'h004, 1'b0, 2};
        vecs[1] = '{8'h3F, 8'h01, CORR ? 9'h040 : 9'h000, 1'b1, CORR ? 3 : 2};
        vecs[2] = '{8'hFF, 8'hFF, 9'h1FE, 1'b0, 2};
        vecs[3] = '{8'h00, 8'h00, 9'h000, 1'b0, 2};
        vecs[4] = '{8'h7F, 8'h01, CORR ? 9'h080 : 9'h040, 1'b1, CORR ? 3 : 2};
        vecs[5] = '{8'h55, 8'hAA, 9'h0FF, 1'b0, 2};
        vecs[6] = '{8'hC2, 8'h7E, CORR ? 9'h140 : 9'h100, 1'b1, CORR ? 3 : 2};

        // Reset values while reset is held.
        #1;
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_res", {23'd0, res_a}, 32'd0);
        check("rst_err_flag", {31'd0, err_flag_a}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt_a}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, vecs[i].lat);
            check("err_cnt_a", {16'd0, err_cnt_a}, cnt_a);
            check("err_cnt_b", {30'd0, err_cnt_b}, cnt_b);
        end

        // Back-pressure: result held stable for five cycles.
        out_ready = 1'b0;
        run_txn(8'h03, 8'h01, 9'h004, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", {31'd0, out_valid_a}, 32'd1);
            check("stall_res", {23'd0, res_a}, 32'h004);
            check("stall_err_flag", {31'd0, err_flag_a}, 32'd0);
            check("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("release_in_ready", {31'd0, in_ready_a}, 32'd1);

        // Clear while idle, then saturate the narrow counter.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        cnt_a = 0; cnt_b = 0;
        check("clr_idle_a", {16'd0, err_cnt_a}, 32'd0);
        check("clr_idle_b", {30'd0, err_cnt_b}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            run_txn(8'h3F, 8'h01, CORR ? 9'h040 : 9'h000, 1'b1, CORR ? 3 : 2);
        end
        check("sat_cnt_a", {16'd0, err_cnt_a}, 32'd5);
        check("sat_cnt_b", {30'd0, err_cnt_b}, 32'd3);

        // Clear asserted in the EVAL cycle of an error transaction wins.
        in1 = 8'h3F; in2 = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_eval_a", {16'd0, err_cnt_a}, 32'd0);
        check("clr_eval_b", {30'd0, err_cnt_b}, 32'd0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10 && !out_valid_a; i++) begin
            @(posedge clk); #1;
        end
        check("clr_eval_out_valid", {31'd0, out_valid_a}, 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid-transaction (in CORRECT when present, else EVAL).
        in1 = 8'h3F; in2 = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (CORR) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("midrst_err_cnt", {16'd0, err_cnt_a}, 32'd0);
        check("midrst_res", {23'd0, res_a}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", {31'd0, out_valid_a}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
